// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory-access pipeline stage. Accepts one instruction at a time from
// execute, performs loads/stores against an internal word-addressed 16-bit
// data memory with WAIT_STATES extra cycles per access, and registers the
// completed result for the writeback unit.
//
// Optional feature macro: DMEM_BOUNDS_CHECK_EN (adds out_fault and suppresses
// accesses whose address has nonzero bits above AW).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  execute handshake (in_ready from state register only)
//   in_isld, in_isst     load / store (both set = load)
//   in_iswb, in_rd       register writeback flag and destination
//   in_aluresult         ALU result, also the memory address
//   in_stdata            store data
//   out_valid            one-cycle completion pulse
//   out_iswb, out_isld, out_rd, out_ldresult, out_aluresult   to writeback
//   out_fault            address fault (DMEM_BOUNDS_CHECK_EN only)
module mem_access_unit #(
    parameter int AW          = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_isld,
    input  logic        in_isst,
    input  logic        in_iswb,
    input  logic [2:0]  in_rd,
    input  logic [15:0] in_aluresult,
    input  logic [15:0] in_stdata,
    output logic        out_valid,
    output logic        out_iswb,
    output logic        out_isld,
    output logic [2:0]  out_rd,
    output logic [15:0] out_ldresult,
    output logic [15:0] out_aluresult
`ifdef DMEM_BOUNDS_CHECK_EN
    ,
    output logic        out_fault
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        hold_isld_q, hold_isld_d;
    logic        hold_isst_q, hold_isst_d;
    logic        hold_iswb_q, hold_iswb_d;
    logic [2:0]  hold_rd_q, hold_rd_d;
    logic [15:0] hold_alu_q, hold_alu_d;
    logic [15:0] hold_sd_q, hold_sd_d;

    logic        out_valid_q, out_valid_d;
    logic        out_iswb_q, out_iswb_d;
    logic        out_isld_q, out_isld_d;
    logic [2:0]  out_rd_q, out_rd_d;
    logic [15:0] out_ld_q, out_ld_d;
    logic [15:0] out_alu_q, out_alu_d;
    logic        out_fault_q, out_fault_d;

    logic [15:0] mem_q [2**AW];

    // Access operands come from the hold registers while BUSY, else straight
    // from execute (single-cycle completion path).
    logic          src_isld, src_isst, src_iswb;
    logic [2:0]    src_rd;
    logic [15:0]   src_alu, src_sd;
    logic          acc_st, acc_fault, mem_we;
    logic [AW-1:0] addr;
    logic [15:0]   rdata;
    logic          complete;

    always_comb begin
        if (state_q == BUSY) begin
            src_isld = hold_isld_q;
            src_isst = hold_isst_q;
            src_iswb = hold_iswb_q;
            src_rd   = hold_rd_q;
            src_alu  = hold_alu_q;
            src_sd   = hold_sd_q;
        end else begin
            src_isld = in_isld;
            src_isst = in_isst;
            src_iswb = in_iswb;
            src_rd   = in_rd;
            src_alu  = in_aluresult;
            src_sd   = in_stdata;
        end
        acc_st = src_isst & ~src_isld;
        addr   = src_alu[AW-1:0];
`ifdef DMEM_BOUNDS_CHECK_EN
        acc_fault = (src_isld | src_isst) & (|src_alu[15:AW]);
`else
        acc_fault = 1'b0;
`endif
        rdata  = mem_q[addr];
        mem_we = complete & acc_st & ~acc_fault;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_isld_d = hold_isld_q;
        hold_isst_d = hold_isst_q;
        hold_iswb_d = hold_iswb_q;
        hold_rd_d   = hold_rd_q;
        hold_alu_d  = hold_alu_q;
        hold_sd_d   = hold_sd_q;
        complete    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!(in_isld | in_isst) || WAIT_STATES == 0) begin
                        complete = 1'b1;
                    end else begin
                        hold_isld_d = in_isld;
                        hold_isst_d = in_isst;
                        hold_iswb_d = in_iswb;
                        hold_rd_d   = in_rd;
                        hold_alu_d  = in_aluresult;
                        hold_sd_d   = in_stdata;
                        cnt_d       = 4'(WAIT_STATES);
                        state_d     = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    complete = 1'b1;
                    cnt_d    = 4'd0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Valid and iswb are pulses; the data fields hold between completions.
        out_valid_d = complete;
        out_iswb_d  = complete & src_iswb & ~acc_st & ~acc_fault;
        out_fault_d = complete & acc_fault;
        out_isld_d  = complete ? src_isld : out_isld_q;
        out_rd_d    = complete ? src_rd : out_rd_q;
        out_alu_d   = complete ? src_alu : out_alu_q;
        out_ld_d    = out_ld_q;
        if (complete) begin
            out_ld_d = (src_isld & ~acc_fault) ? rdata : 16'h0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            hold_isld_q <= 1'b0;
            hold_isst_q <= 1'b0;
            hold_iswb_q <= 1'b0;
            hold_rd_q   <= 3'd0;
            hold_alu_q  <= 16'h0000;
            hold_sd_q   <= 16'h0000;
            out_valid_q <= 1'b0;
            out_iswb_q  <= 1'b0;
            out_isld_q  <= 1'b0;
            out_rd_q    <= 3'd0;
            out_ld_q    <= 16'h0000;
            out_alu_q   <= 16'h0000;
            out_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_isld_q <= hold_isld_d;
            hold_isst_q <= hold_isst_d;
            hold_iswb_q <= hold_iswb_d;
            hold_rd_q   <= hold_rd_d;
            hold_alu_q  <= hold_alu_d;
            hold_sd_q   <= hold_sd_d;
            out_valid_q <= out_valid_d;
            out_iswb_q  <= out_iswb_d;
            out_isld_q  <= out_isld_d;
            out_rd_q    <= out_rd_d;
            out_ld_q    <= out_ld_d;
            out_alu_q   <= out_alu_d;
            out_fault_q <= out_fault_d;
        end
    end

    // Data memory is deliberately not reset. The write enable derives from
    // the reset state register, so an op held in BUSY is dropped by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr] <= src_sd;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = out_valid_q;
    assign out_iswb      = out_iswb_q;
    assign out_isld      = out_isld_q;
    assign out_rd        = out_rd_q;
    assign out_ldresult  = out_ld_q;
    assign out_aluresult = out_alu_q;
`ifdef DMEM_BOUNDS_CHECK_EN
    assign out_fault     = out_fault_q;
`else
    // Fault flag is only meaningful with bounds checking enabled.
    logic unused_fault;
    assign unused_fault  = out_fault_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: DUT 0 with WAIT_STATES=2, DUT 1 with WAIT_STATES=0.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        v [2], rdy [2], isld_i [2], isst_i [2], iswb_i [2];
    logic [2:0]  rd_i [2];
    logic [15:0] alu_i [2], sd_i [2];
    logic        ov [2], owb [2], old [2], of [2];
    logic [2:0]  ord [2];
    logic [15:0] oldr [2], oalu [2];

    mem_access_unit #(.AW(8), .WAIT_STATES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_ready(rdy[0]),
        .in_isld(isld_i[0]), .in_isst(isst_i[0]), .in_iswb(iswb_i[0]),
        .in_rd(rd_i[0]), .in_aluresult(alu_i[0]), .in_stdata(sd_i[0]),
        .out_valid(ov[0]), .out_iswb(owb[0]), .out_isld(old[0]), .out_rd(ord[0]),
        .out_ldresult(oldr[0]), .out_aluresult(oalu[0])
`ifdef DMEM_BOUNDS_CHECK_EN
        , .out_fault(of[0])
`endif
    );

    mem_access_unit #(.AW(8), .WAIT_STATES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v[1]), .in_ready(rdy[1]),
        .in_isld(isld_i[1]), .in_isst(isst_i[1]), .in_iswb(iswb_i[1]),
        .in_rd(rd_i[1]), .in_aluresult(alu_i[1]), .in_stdata(sd_i[1]),
        .out_valid(ov[1]), .out_iswb(owb[1]), .out_isld(old[1]), .out_rd(ord[1]),
        .out_ldresult(oldr[1]), .out_aluresult(oalu[1])
`ifdef DMEM_BOUNDS_CHECK_EN
        , .out_fault(of[1])
`endif
    );

`ifndef DMEM_BOUNDS_CHECK_EN
    assign of[0] = 1'b0;
    assign of[1] = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted memory op completes W edges after its
    // accept edge (absolute edge numbers), anything else on the accept edge.
    typedef struct packed {
        logic ld, st, wb;
        logic [2:0] rd;
        logic [15:0] alu, sd;
    } op_t;

    logic [15:0] mm [2][256];
    int   cyc = 0;
    bit   pend [2];
    int   due [2];
    op_t  p [2];
    logic e_v [2], e_wb [2], e_ld [2], e_f [2];
    logic [2:0]  e_rd [2];
    logic [15:0] e_ldr [2], e_alu [2];

    function automatic int wfor(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic op_t cur(input int d);
        return '{ld: isld_i[d], st: isst_i[d], wb: iswb_i[d], rd: rd_i[d], alu: alu_i[d], sd: sd_i[d]};
    endfunction

    function automatic bit is_mem(input op_t o);
        return o.ld | o.st;
    endfunction

    function automatic bit flt(input op_t o);
`ifdef DMEM_BOUNDS_CHECK_EN
        return is_mem(o) && (o.alu[15:8] != 8'h00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic complete(input int d, input op_t o);
        bit st;
        st = o.st & ~o.ld;
        e_v[d]   <= 1'b1;
        e_wb[d]  <= o.wb & ~st & ~flt(o);
        e_f[d]   <= flt(o);
        e_ld[d]  <= o.ld;
        e_rd[d]  <= o.rd;
        e_alu[d] <= o.alu;
        e_ldr[d] <= (o.ld && !flt(o)) ? mm[d][o.alu[7:0]] : 16'h0000;
        if (st && !flt(o)) mm[d][o.alu[7:0]] <= o.sd;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0;
            for (int d = 0; d < 2; d++) begin
                pend[d] <= 1'b0; e_v[d] <= 1'b0; e_wb[d] <= 1'b0; e_ld[d] <= 1'b0;
                e_f[d] <= 1'b0; e_rd[d] <= 3'd0; e_ldr[d] <= 16'h0; e_alu[d] <= 16'h0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int d = 0; d < 2; d++) begin
                e_v[d] <= 1'b0; e_wb[d] <= 1'b0; e_f[d] <= 1'b0;
                if (pend[d]) begin
                    if (cyc + 1 == due[d]) begin
                        complete(d, p[d]);
                        pend[d] <= 1'b0;
                    end
                end else if (v[d]) begin
                    if (!is_mem(cur(d)) || wfor(d) == 0) begin
                        complete(d, cur(d));
                    end else begin
                        pend[d] <= 1'b1;
                        due[d]  <= cyc + 1 + wfor(d);
                        p[d]    <= cur(d);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk("ready", rdy[d], !pend[d]);
            chk("valid", ov[d], e_v[d]);
            chk("iswb", owb[d], e_wb[d]);
            chk("isld", old[d], e_ld[d]);
            chk("rd", ord[d], e_rd[d]);
            chk("ldresult", oldr[d], e_ldr[d]);
            chk("aluresult", oalu[d], e_alu[d]);
            chk("fault", of[d], e_f[d]);
        end
    end

    task automatic drive(input int d, input logic ld, input logic st, input logic wb,
                         input logic [2:0] rd, input logic [15:0] alu, input logic [15:0] sd);
        v[d] = 1'b1; isld_i[d] = ld; isst_i[d] = st; iswb_i[d] = wb;
        rd_i[d] = rd; alu_i[d] = alu; sd_i[d] = sd;
    endtask

    task automatic send(input int d, input logic ld, input logic st, input logic wb,
                        input logic [2:0] rd, input logic [15:0] alu, input logic [15:0] sd);
        int n;
        n = 0;
        @(negedge clk);
        drive(d, ld, st, wb, rd, alu, sd);
        while (!rdy[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", n, 0);
        @(posedge clk);
    endtask

    task automatic wait_out(input int d, output int n, output int low);
        n = 0;
        low = 0;
        do begin
            @(negedge clk);
            v[d] = 1'b0;
            n++;
            if (!rdy[d]) low++;
        end while (!ov[d] && n < 20);
    endtask

    int n, low;

    initial begin
        for (int d = 0; d < 2; d++) begin
            v[d] = 0; isld_i[d] = 0; isst_i[d] = 0; iswb_i[d] = 0;
            rd_i[d] = 0; alu_i[d] = 0; sd_i[d] = 0;
            for (int a = 0; a < 256; a++) mm[d][a] = 16'h0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ready", rdy[0], 1);
        chk("rst_valid", ov[0], 0);
        chk("rst_alu", oalu[0], 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Reset while a store is held in BUSY
        send(0, 0, 1, 0, 3'd0, 16'h0005, 16'hBEEF);
        @(negedge clk);
        v[0] = 1'b0;
        chk("busy_before_rst", rdy[0], 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", rdy[0], 1);
        chk("midrst_valid", ov[0], 0);
        chk("midrst_iswb", owb[0], 0);
        chk("midrst_fault", of[0], 0);
        @(negedge clk);
        chk("midrst_valid2", ov[0], 0);
        #2 rst_n = 1'b1;
        send(0, 1, 0, 1, 3'd1, 16'h0005, 16'h0);
        wait_out(0, n, low);
        chk("discarded_store_ld", oldr[0], 16'h0000);

        // Store then load, W=2; store has iswb=1 to check suppression
        send(0, 0, 1, 1, 3'd2, 16'h0010, 16'h1234);
        wait_out(0, n, low);
        chk("st_latency", n, 3);
        chk("st_ready_low", low, 2);
        chk("st_valid", ov[0], 1);
        chk("st_iswb_suppr", owb[0], 0);
        send(0, 1, 0, 1, 3'd3, 16'h0010, 16'h0);
        wait_out(0, n, low);
        chk("ld_latency", n, 3);
        chk("ld_ready_low", low, 2);
        chk("ld_isld", old[0], 1);
        chk("ld_iswb", owb[0], 1);
        chk("ld_rd", ord[0], 3);
        chk("ld_data", oldr[0], 16'h1234);

        // Four back-to-back ALU ops
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("alu_valid", ov[0], 1);
                chk("alu_result", oalu[0], 16'h00A5);
                chk("alu_rd", ord[0], 6);
                chk("alu_iswb", owb[0], 1);
            end
            chk("alu_ready", rdy[0], 1);
            if (i < 4) drive(0, 0, 0, 1, 3'd6, 16'h00A5, 16'h0);
            else v[0] = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        chk("alu_valid_drop", ov[0], 0);

        // Out-of-range store, then load of the wrapped address
        send(0, 0, 1, 1, 3'd4, 16'h0105, 16'h5555);
        wait_out(0, n, low);
        chk("oor_st_latency", n, 3);
`ifdef DMEM_BOUNDS_CHECK_EN
        chk("oor_fault", of[0], 1);
`endif
        send(0, 1, 0, 1, 3'd5, 16'h0005, 16'h0);
        wait_out(0, n, low);
`ifdef DMEM_BOUNDS_CHECK_EN
        chk("oor_ld", oldr[0], 16'h0000);
`else
        chk("oor_ld", oldr[0], 16'h5555);
`endif

        // W=0: store then load of the same address on the next cycle
        @(negedge clk);
        drive(1, 0, 1, 0, 3'd1, 16'h0020, 16'h7777);
        @(posedge clk);
        @(negedge clk);
        chk("w0_st_valid", ov[1], 1);
        chk("w0_st_ready", rdy[1], 1);
        drive(1, 1, 0, 1, 3'd2, 16'h0020, 16'h0);
        @(posedge clk);
        @(negedge clk);
        v[1] = 1'b0;
        chk("w0_ld_valid", ov[1], 1);
        chk("w0_ld_ready", rdy[1], 1);
        chk("w0_ld_data", oldr[1], 16'h7777);
        chk("w0_ld_rd", ord[1], 2);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
